ack_bus_arbiter_rr: RTL and testbench
=====================================

Name: ack_bus_arbiter_rr

Overview:
Parametrised, registered successor to the combinational ACK-bus arbiter. It arbitrates N_REQ requesters for the shared ACK bus, in either fixed-priority or round-robin mode. The winner holds the grant until it drops its request, and a programmable turnaround gap separates grants. It sits between the module ACK requesters (MEM/SHA/AES/CTRL and future engines) and the ACK bus mux, and broadcasts the registered winner ID to all modules.

Parameters:
N_REQ, 4, number of requesters (1..16); index N_REQ-1 is the highest fixed priority (CTRL is wired there).
ID_W, max(1,$clog2(N_REQ)), width of winner_id.
TURNAROUND, 1, idle cycles inserted between a release and the next grant (0..3).
MAX_HOLD, 255, grant-hold cycle limit, used only with ACK_ARB_TIMEOUT_EN (1..2^16-1).

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
req  input  N_REQ  per-requester ACK request; held high for the whole transfer.
rr_mode  input  1  0 = fixed priority (highest index wins), 1 = round-robin.
grant  output  N_REQ  registered one-hot grant to the winner.
grant_valid  output  1  registered; 1 when exactly one grant bit is set.
winner_id  output  ID_W  registered index of the current or most recent winner.
ack_event  output  1  combinational OR of req.
busy  output  1  1 in GRANT or GAP state.
timeout_pulse  output  1  one-cycle pulse on forced release; tied 0 without ACK_ARB_TIMEOUT_EN.

Behaviour:
- Reset (asynchronous, effective immediately, including mid-grant):
  - grant=0, grant_valid=0, busy=0, timeout_pulse=0.
  - winner_id = all ones truncated to ID_W.
  - RR pointer = 0; state = IDLE; gap and hold counters = 0.
- FSM states: IDLE, GRANT, GAP.
  - IDLE: if any effective req bit is set at edge t, then at t+1: grant = onehot(sel), grant_valid=1, winner_id=sel, state=GRANT. Request-to-grant latency is 1 cycle.
  - GRANT: grant is held while req[winner_id]=1.
    - If req[winner_id] is sampled 0 and TURNAROUND>0: next cycle grant=0, grant_valid=0, state=GAP, gap counter loads TURNAROUND-1.
    - If req[winner_id] is sampled 0 and TURNAROUND=0: arbitrate among the other effective requests in the same edge. A winner goes to GRANT back-to-back (grant switches directly from the old one-hot to the new one). No winner goes to IDLE.
  - GAP: gap counter decrements each cycle. At 0, arbitrate exactly as in IDLE; no requests returns to IDLE. A GAP lasts exactly TURNAROUND cycles.
- Selection:
  - Fixed mode: the highest set index wins.
  - RR mode: search starts at the pointer and increments modulo N_REQ (wrap from N_REQ-1 to 0, including non-power-of-2 N_REQ).
  - On every grant issue, pointer = (sel+1) mod N_REQ, in both modes so that switching modes is well defined.
- rr_mode is sampled only at arbitration edges; changing it mid-grant has no effect on the current holder.
- A request from a non-winner that drops before it is granted is simply lost; no queueing.
- winner_id keeps the last winner value while in IDLE or GAP.
- grant is always zero or one-hot; grant_valid == |grant.
- N_REQ=1: the single requester is always selected; the pointer stays 0.

Optional Feature:
Macro ACK_ARB_TIMEOUT_EN.
- When defined: a 16-bit hold counter clears on grant issue and increments each GRANT cycle. When it reaches MAX_HOLD with req[winner] still high:
  - the grant is force-released on the next edge, with normal GAP/TURNAROUND handling;
  - timeout_pulse=1 for that one cycle;
  - the offender's req is masked from arbitration (effective req = 0) until it is sampled low once.
- When not defined: no counter or mask logic; timeout_pulse is constant 0; a grant is held indefinitely.

Test Plan:
1. Reset, then rr_mode=0, req=4'b1011 at cycle 0 -> cycle 1: grant=4'b1000, winner_id=3, grant_valid=1; ack_event=1 from cycle 0.
2. rr_mode=1, TURNAROUND=1, req=4'b1111 held, each winner drops req after 2 grant cycles -> grant order 0,1,2,3,0; grant=0 for exactly 1 cycle between grants.
3. TURNAROUND=0, req[1] and req[2] high, rr_mode=1 -> grant 4'b0010, then 4'b0100 on the cycle after req[1] is sampled low, with no zero cycle in between.
4. rst_n pulled low mid-grant (asynchronously, between edges) -> grant=0, grant_valid=0, winner_id=2'b11 immediately; first grant after release starts from pointer 0.
5. N_REQ=3, rr_mode=1, pointer=2, req=3'b011 -> grant index 0, pointer becomes 1 (wrap check).
6. ACK_ARB_TIMEOUT_EN, MAX_HOLD=8, req[0] stuck high alone -> grant released after 8 hold cycles, timeout_pulse=1 for one cycle; req[0] not re-granted until it toggles low and high again.

Source files
------------

// File: rtl/ack_bus_arbiter_rr_if.sv
// ack_bus_arbiter_rr_if: request/grant bundle between the ACK requesters and
// the ACK bus arbiter.
//
// Handshake: a requester raises req[i] and holds it high for its whole
// transfer. The arbiter answers with a registered one-hot grant one cycle
// after it samples the request. The winner owns the bus for as long as its
// req stays high. Dropping req releases the bus, and grant falls on the
// following edge. grant_valid is always equal to |grant.
interface ack_bus_arbiter_rr_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
);
  logic [N_REQ-1:0] req;
  logic             rr_mode;
  logic [N_REQ-1:0] grant;
  logic             grant_valid;
  logic [ID_W-1:0]  winner_id;
  logic             ack_event;
  logic             busy;
  logic             timeout_pulse;

  // Requester side
  modport master (
    output req, rr_mode,
    input  grant, grant_valid, winner_id, ack_event, busy, timeout_pulse
  );

  // Arbiter side
  modport slave (
    input  req, rr_mode,
    output grant, grant_valid, winner_id, ack_event, busy, timeout_pulse
  );
endinterface

// File: rtl/ack_bus_arbiter_rr.sv
// ack_bus_arbiter_rr: registered ACK-bus arbiter for N_REQ requesters.
// Supports fixed-priority mode (highest index wins) and round-robin mode.
// The winner holds the grant until it drops req. TURNAROUND idle cycles
// separate one grant from the next.
// Optional macro ACK_ARB_TIMEOUT_EN adds a MAX_HOLD grant limit. The holder
// is force-released when the limit is reached and stays masked until it
// drops its req once.
module ack_bus_arbiter_rr #(
  parameter int N_REQ      = 4,
  parameter int ID_W       = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  parameter int TURNAROUND = 1,
  parameter int MAX_HOLD   = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ack_bus_arbiter_rr_if.slave  bus,
  output logic [1:0]           dbg_state_o
);

  if (N_REQ < 1 || N_REQ > 16 || TURNAROUND < 0 || TURNAROUND > 3 ||
      MAX_HOLD < 1 || MAX_HOLD > 65535) begin : g_param_check
    $error("ack_bus_arbiter_rr: parameter out of range");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_e;

  // The gap counter counts down to zero, so a GAP of TURNAROUND cycles loads TURNAROUND-1.
  localparam logic [1:0]      GAP_LOAD = (TURNAROUND > 0) ? 2'(TURNAROUND - 1) : 2'd0;
  localparam logic [ID_W-1:0] LAST_IDX = ID_W'(N_REQ - 1);

  state_e           state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic             valid_q;
  logic [ID_W-1:0]  winner_q, winner_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [1:0]       gap_q, gap_d;

  logic [N_REQ-1:0] eff_req;
  logic [N_REQ-1:0] arb_req;
  logic             held;
  logic             force_rel;
  logic             arb_en;
  logic             issue;
  logic             sel_found;
  logic [ID_W-1:0]  sel_idx;

  // Round-robin candidate index: pointer plus offset, wrapped at N_REQ.
  function automatic logic [ID_W-1:0] rr_idx(input logic [ID_W-1:0] base, input int offset);
    int s;
    s = int'(base) + offset;
    if (s >= N_REQ) s = s - N_REQ;
    return ID_W'(s);
  endfunction

  // The current holder still wants the bus.
  assign held = |(grant_q & bus.req);

  // The holder's own slot is never a candidate at its release edge.
  assign arb_req = eff_req & ~grant_q;

  // Winner selection for the arbitration edge.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    if (bus.rr_mode) begin
      // Walk offsets from far to near so that the nearest hit to the pointer wins.
      for (int k = N_REQ - 1; k >= 0; k--) begin
        if (arb_req[rr_idx(ptr_q, k)]) begin
          sel_found = 1'b1;
          sel_idx   = rr_idx(ptr_q, k);
        end
      end
    end else begin
      // The highest set index wins.
      for (int i = 0; i < N_REQ; i++) begin
        if (arb_req[i]) begin
          sel_found = 1'b1;
          sel_idx   = ID_W'(i);
        end
      end
    end
  end

  // Next-state and next-grant logic for IDLE/GRANT/GAP.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    winner_d = winner_q;
    ptr_d    = ptr_q;
    gap_d    = gap_q;
    arb_en   = 1'b0;
    case (state_q)
      IDLE: arb_en = 1'b1;
      GRANT: begin
        if (!held || force_rel) begin
          if (TURNAROUND > 0) begin
            state_d = GAP;
            grant_d = '0;
            gap_d   = GAP_LOAD;
          end else begin
            arb_en = 1'b1;
          end
        end
      end
      GAP: begin
        if (gap_q != 2'd0) gap_d = gap_q - 2'd1;
        else               arb_en = 1'b1;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
    if (arb_en) begin
      if (sel_found) begin
        state_d  = GRANT;
        grant_d  = N_REQ'(1) << sel_idx;
        winner_d = sel_idx;
        ptr_d    = (sel_idx == LAST_IDX) ? '0 : sel_idx + ID_W'(1);
      end else begin
        state_d = IDLE;
        grant_d = '0;
      end
    end
  end

  assign issue = arb_en && sel_found;

  // State, grant and pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      valid_q  <= 1'b0;
      winner_q <= '1;
      ptr_q    <= '0;
      gap_q    <= 2'd0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      valid_q  <= |grant_d;
      winner_q <= winner_d;
      ptr_q    <= ptr_d;
      gap_q    <= gap_d;
    end
  end

`ifdef ACK_ARB_TIMEOUT_EN
  localparam logic [15:0] HOLD_LAST = 16'(MAX_HOLD - 1);

  logic [15:0]      hold_q, hold_d;
  logic [N_REQ-1:0] mask_q, mask_d;
  logic             tmo_q;

  // hold_q counts completed grant cycles. The release is forced at the edge
  // that ends the MAX_HOLD-th grant cycle.
  assign force_rel = (state_q == GRANT) && held && (hold_q == HOLD_LAST);
  assign eff_req   = bus.req & ~mask_q;

  // Hold counter and offender mask. A mask bit clears once its req is seen low.
  always_comb begin
    hold_d = hold_q;
    if (issue)                  hold_d = 16'd0;
    else if (state_q == GRANT)  hold_d = hold_q + 16'd1;
    mask_d = mask_q & bus.req;
    if (force_rel) mask_d = mask_d | grant_q;
  end

  // Timeout registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= 16'd0;
      mask_q <= '0;
      tmo_q  <= 1'b0;
    end else begin
      hold_q <= hold_d;
      mask_q <= mask_d;
      tmo_q  <= force_rel;
    end
  end

  assign bus.timeout_pulse = tmo_q;
`else
  assign force_rel         = 1'b0;
  assign eff_req           = bus.req;
  assign bus.timeout_pulse = 1'b0;
`endif

  assign bus.grant       = grant_q;
  assign bus.grant_valid = valid_q;
  assign bus.winner_id   = winner_q;
  assign bus.ack_event   = |bus.req;
  assign bus.busy        = (state_q != IDLE);
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_ack_bus_arbiter_rr.sv
// tb_ack_bus_arbiter_rr: self-checking bench for ack_bus_arbiter_rr.
// It uses three instances: A (N_REQ=4, TURNAROUND=1), B (N_REQ=4,
// TURNAROUND=0) and C (N_REQ=3, TURNAROUND=2, MAX_HOLD=8).
module tb_ack_bus_arbiter_rr;

  localparam int N_OF  [3] = '{4, 4, 3};
  localparam int T_OF  [3] = '{1, 0, 2};
  localparam int MH_OF [3] = '{255, 255, 8};
`ifdef ACK_ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] req_v [3];
  logic        rr_v;

  ack_bus_arbiter_rr_if #(.N_REQ(4)) if_a ();
  ack_bus_arbiter_rr_if #(.N_REQ(4)) if_b ();
  ack_bus_arbiter_rr_if #(.N_REQ(3)) if_c ();

  logic [1:0] dbg_st [3];

  ack_bus_arbiter_rr #(.N_REQ(4), .TURNAROUND(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(if_a), .dbg_state_o(dbg_st[0]));
  ack_bus_arbiter_rr #(.N_REQ(4), .TURNAROUND(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(if_b), .dbg_state_o(dbg_st[1]));
  ack_bus_arbiter_rr #(.N_REQ(3), .TURNAROUND(2), .MAX_HOLD(8)) dut_c (
    .clk(clk), .rst_n(rst_n), .bus(if_c), .dbg_state_o(dbg_st[2]));

  assign if_a.req = req_v[0][3:0];
  assign if_b.req = req_v[1][3:0];
  assign if_c.req = req_v[2][2:0];
  assign if_a.rr_mode = rr_v;
  assign if_b.rr_mode = rr_v;
  assign if_c.rr_mode = rr_v;

  logic [15:0] act_grant [3];
  logic [15:0] act_id    [3];
  logic        act_valid [3];
  logic        act_busy  [3];
  logic        act_tmo   [3];
  logic        act_ack   [3];

  assign act_grant[0] = 16'(if_a.grant);
  assign act_grant[1] = 16'(if_b.grant);
  assign act_grant[2] = 16'(if_c.grant);
  assign act_id[0]    = 16'(if_a.winner_id);
  assign act_id[1]    = 16'(if_b.winner_id);
  assign act_id[2]    = 16'(if_c.winner_id);
  assign act_valid[0] = if_a.grant_valid;
  assign act_valid[1] = if_b.grant_valid;
  assign act_valid[2] = if_c.grant_valid;
  assign act_busy[0]  = if_a.busy;
  assign act_busy[1]  = if_b.busy;
  assign act_busy[2]  = if_c.busy;
  assign act_tmo[0]   = if_a.timeout_pulse;
  assign act_tmo[1]   = if_b.timeout_pulse;
  assign act_tmo[2]   = if_c.timeout_pulse;
  assign act_ack[0]   = if_a.ack_event;
  assign act_ack[1]   = if_b.ack_event;
  assign act_ack[2]   = if_c.ack_event;

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_dut(input int d, input string tag, input logic [15:0] eg,
                           input logic ev, input logic [15:0] eid, input logic eb,
                           input logic et);
    chk($sformatf("%s[%0d].grant", tag, d),       act_grant[d], eg);
    chk($sformatf("%s[%0d].grant_valid", tag, d), act_valid[d], ev);
    chk($sformatf("%s[%0d].winner_id", tag, d),   act_id[d],    eid);
    chk($sformatf("%s[%0d].busy", tag, d),        act_busy[d],  eb);
    chk($sformatf("%s[%0d].timeout", tag, d),     act_tmo[d],   et);
    chk($sformatf("%s[%0d].ack_event", tag, d),   act_ack[d],   |req_v[d]);
  endtask

  // ---------------- reference model ----------------
  // Each instance is described by: who holds the bus (-1 = nobody), how many
  // idle gap cycles are still due, the round-robin start index, the last
  // winner, how many cycles the holder has been granted, and the offenders
  // that are masked.
  int          m_holder [3];
  int          m_gap    [3];
  int          m_ptr    [3];
  int          m_last   [3];
  int          m_cnt    [3];
  logic [15:0] m_mask   [3];
  bit          m_tmo    [3];

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_holder[d] = -1;
      m_gap[d]    = 0;
      m_ptr[d]    = 0;
      m_last[d]   = 3;
      m_cnt[d]    = 0;
      m_mask[d]   = '0;
      m_tmo[d]    = 1'b0;
    end
  endtask

  function automatic int pick(input int d, input logic [15:0] cand, input bit rr);
    int sel;
    sel = -1;
    if (!rr) begin
      for (int i = 0; i < N_OF[d]; i++) if (cand[i]) sel = i;
    end else begin
      for (int k = 0; k < N_OF[d]; k++) begin
        if (sel < 0 && cand[(m_ptr[d] + k) % N_OF[d]]) sel = (m_ptr[d] + k) % N_OF[d];
      end
    end
    return sel;
  endfunction

  task automatic model_step(input int d, input logic [15:0] r, input bit rr);
    logic [15:0] elig;
    logic [15:0] excl;
    bit          do_arb;
    int          sel;
    elig      = r & ~m_mask[d];
    m_mask[d] = m_mask[d] & r;
    m_tmo[d]  = 1'b0;
    excl      = '0;
    do_arb    = 1'b0;
    if (m_holder[d] >= 0) begin
      if (r[m_holder[d]] && !(TMO_EN && m_cnt[d] >= MH_OF[d])) begin
        m_cnt[d]++;
      end else begin
        if (r[m_holder[d]]) begin
          m_tmo[d]  = 1'b1;
          m_mask[d] = m_mask[d] | (16'd1 << m_holder[d]);
        end
        excl        = 16'd1 << m_holder[d];
        m_holder[d] = -1;
        if (T_OF[d] > 0) m_gap[d] = T_OF[d];
        else             do_arb = 1'b1;
      end
    end else if (m_gap[d] > 0) begin
      m_gap[d]--;
      if (m_gap[d] == 0) do_arb = 1'b1;
    end else begin
      do_arb = 1'b1;
    end
    if (do_arb) begin
      sel = pick(d, elig & ~excl, rr);
      if (sel >= 0) begin
        m_holder[d] = sel;
        m_last[d]   = sel;
        m_ptr[d]    = (sel + 1) % N_OF[d];
        m_cnt[d]    = 1;
      end
    end
  endtask

  task automatic model_check(input int d);
    logic [15:0] eg;
    eg = (m_holder[d] >= 0) ? 16'(1 << m_holder[d]) : 16'd0;
    check_dut(d, "rand", eg, m_holder[d] >= 0, 16'(m_last[d]),
              (m_holder[d] >= 0) || (m_gap[d] > 0), m_tmo[d]);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    for (int d = 0; d < 3; d++) req_v[d] = '0;
    rr_v = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      check_dut(d, "reset", 16'd0, 1'b0, 16'd3, 1'b0, 1'b0);
      chk($sformatf("reset[%0d].state", d), 32'(dbg_st[d]), 32'd0);
    end
    rst_n = 1'b1;
    model_reset();
  endtask

  // ---------------- directed vector table (instance A) ----------------
  typedef struct {
    logic [3:0] req;
    logic       rr;
    logic [3:0] grant;
    logic       valid;
    logic [1:0] id;
    logic       busy;
  } vec_t;

  vec_t vecs [12];

  initial begin
    vecs[0]  = '{4'b1011, 1'b0, 4'b1000, 1'b1, 2'd3, 1'b1};
    vecs[1]  = '{4'b1011, 1'b0, 4'b1000, 1'b1, 2'd3, 1'b1};
    vecs[2]  = '{4'b0011, 1'b0, 4'b0000, 1'b0, 2'd3, 1'b1};
    vecs[3]  = '{4'b0011, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b1};
    vecs[4]  = '{4'b0011, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1};
    vecs[5]  = '{4'b0001, 1'b1, 4'b0000, 1'b0, 2'd1, 1'b1};
    vecs[6]  = '{4'b1101, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b1};
    vecs[7]  = '{4'b1001, 1'b1, 4'b0000, 1'b0, 2'd2, 1'b1};
    vecs[8]  = '{4'b1001, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b1};
    vecs[9]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd3, 1'b1};
    vecs[10] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd3, 1'b0};
    vecs[11] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd3, 1'b0};

    rst_n = 1'b0;
    rr_v  = 1'b0;
    for (int d = 0; d < 3; d++) req_v[d] = '0;
    model_reset();

    // Table: fixed priority, mid-grant mode change, round robin, return to idle
    do_reset();
    for (int v = 0; v < 12; v++) begin
      req_v[0] = 16'(vecs[v].req);
      rr_v     = vecs[v].rr;
      #1;
      chk($sformatf("vec%0d.ack_comb", v), act_ack[0], |vecs[v].req);
      tick();
      check_dut(0, $sformatf("vec%0d", v), 16'(vecs[v].grant), vecs[v].valid,
                16'(vecs[v].id), vecs[v].busy, 1'b0);
    end

    // Round-robin order 0,1,2,3,0 with a one-cycle gap between grants
    do_reset();
    rr_v     = 1'b1;
    req_v[0] = 16'hF;
    for (int k = 0; k < 5; k++) begin
      tick();
      check_dut(0, "rr_first", 16'(1 << (k % 4)), 1'b1, 16'(k % 4), 1'b1, 1'b0);
      tick();
      check_dut(0, "rr_hold", 16'(1 << (k % 4)), 1'b1, 16'(k % 4), 1'b1, 1'b0);
      req_v[0] = 16'hF & ~16'(1 << (k % 4));
      tick();
      check_dut(0, "rr_gap", 16'd0, 1'b0, 16'(k % 4), 1'b1, 1'b0);
      req_v[0] = 16'hF;
    end

    // Zero turnaround: the grant moves to the next requester with no empty cycle
    do_reset();
    rr_v     = 1'b1;
    req_v[1] = 16'b0110;
    tick();
    check_dut(1, "b2b_first", 16'b0010, 1'b1, 16'd1, 1'b1, 1'b0);
    tick();
    check_dut(1, "b2b_hold", 16'b0010, 1'b1, 16'd1, 1'b1, 1'b0);
    req_v[1] = 16'b0100;
    tick();
    check_dut(1, "b2b_switch", 16'b0100, 1'b1, 16'd2, 1'b1, 1'b0);

    // Asynchronous reset between edges while a grant is held
    do_reset();
    rr_v     = 1'b1;
    req_v[0] = 16'b0100;
    tick();
    check_dut(0, "arst_pre", 16'b0100, 1'b1, 16'd2, 1'b1, 1'b0);
    tick();
    #2 rst_n = 1'b0;
    #1;
    check_dut(0, "arst_now", 16'd0, 1'b0, 16'd3, 1'b0, 1'b0);
    #2 rst_n = 1'b1;
    req_v[0] = 16'hF;
    tick();
    check_dut(0, "arst_ptr0", 16'b0001, 1'b1, 16'd0, 1'b1, 1'b0);

    // N_REQ=3: round-robin pointer wraps from 2 to 0, then advances to 1
    do_reset();
    rr_v     = 1'b1;
    req_v[2] = 16'b010;
    tick();
    check_dut(2, "wrap_g1", 16'b010, 1'b1, 16'd1, 1'b1, 1'b0);
    req_v[2] = 16'b000;
    tick();
    check_dut(2, "wrap_gap1", 16'd0, 1'b0, 16'd1, 1'b1, 1'b0);
    req_v[2] = 16'b011;
    tick();
    check_dut(2, "wrap_gap2", 16'd0, 1'b0, 16'd1, 1'b1, 1'b0);
    tick();
    check_dut(2, "wrap_g0", 16'b001, 1'b1, 16'd0, 1'b1, 1'b0);
    req_v[2] = 16'b010;
    tick();
    check_dut(2, "wrap_rel", 16'd0, 1'b0, 16'd0, 1'b1, 1'b0);
    req_v[2] = 16'b011;
    tick();
    check_dut(2, "wrap_gap3", 16'd0, 1'b0, 16'd0, 1'b1, 1'b0);
    tick();
    check_dut(2, "wrap_ptr1", 16'b010, 1'b1, 16'd1, 1'b1, 1'b0);

    // Stuck requester on instance C (MAX_HOLD=8)
    do_reset();
    rr_v     = 1'b0;
    req_v[2] = 16'b001;
    tick();
    check_dut(2, "stuck_first", 16'b001, 1'b1, 16'd0, 1'b1, 1'b0);
`ifdef ACK_ARB_TIMEOUT_EN
    for (int i = 2; i <= 8; i++) begin
      tick();
      check_dut(2, "tmo_hold", 16'b001, 1'b1, 16'd0, 1'b1, 1'b0);
    end
    tick();
    check_dut(2, "tmo_release", 16'd0, 1'b0, 16'd0, 1'b1, 1'b1);
    tick();
    check_dut(2, "tmo_gap", 16'd0, 1'b0, 16'd0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_dut(2, "tmo_masked", 16'd0, 1'b0, 16'd0, 1'b0, 1'b0);
    end
    req_v[2] = 16'b000;
    tick();
    check_dut(2, "tmo_low", 16'd0, 1'b0, 16'd0, 1'b0, 1'b0);
    req_v[2] = 16'b001;
    tick();
    check_dut(2, "tmo_regrant", 16'b001, 1'b1, 16'd0, 1'b1, 1'b0);
`else
    for (int i = 0; i < 20; i++) begin
      tick();
      check_dut(2, "stuck_hold", 16'b001, 1'b1, 16'd0, 1'b1, 1'b0);
    end
`endif

    // Randomized traffic checked against the reference model
    do_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int d = 0; d < 3; d++) begin
        for (int i = 0; i < N_OF[d]; i++) begin
          if ($urandom_range(0, 5) == 0) req_v[d][i] = ~req_v[d][i];
        end
      end
      if ($urandom_range(0, 49) == 0) rr_v = ~rr_v;
      tick();
      for (int d = 0; d < 3; d++) begin
        model_step(d, req_v[d], rr_v);
        model_check(d);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
